// File: rtl/sobel_window_gen_pkg.sv
// ============================================================================
// Module : sobel_pkg
// Brief  : Shared types and constants for the Sobel 3x3 window generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sobel_pkg;

  // Default widths of the pixel input and the weighted output magnitudes.
  localparam int c_PIX_W_DEF  = 8;
  localparam int c_DATA_W_DEF = 12;

  // Per-group kernel weights (1,2,1); the centre tap is a left shift by one.
  localparam int c_WK0 = 1;
  localparam int c_WK1 = 2;
  localparam int c_WK2 = 1;

  // Gradient direction carried alongside every accepted pixel.
  typedef enum logic {
    DIR_GX = 1'b0,
    DIR_GY = 1'b1
  } sobel_dir_t;

  // Nine weighted magnitudes in adder ordering (entry 0 is data1).
  typedef logic [8:0][c_DATA_W_DEF-1:0] sobel_win_t;

endpackage

`default_nettype wire

// File: rtl/sobel_window_gen_line_buf.sv
// ============================================================================
// Module : sobel_line_buf
// Brief  : One image line of storage. A single address is read and written in
//          the same cycle; the read returns the value before the write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read-before-write RAM port; contents are never cleared (stale data is
  // masked by the row qualification in the window generator).
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata        <= r_mem[i_addr];
      r_mem[i_addr]  <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sobel_window_gen.sv
// ============================================================================
// Module : sobel_window_gen
// Brief  : Streaming 3x3 window generator feeding the Sobel row-sum adder.
//          Buffers two lines, forms a 3x3 window per accepted pixel and emits
//          nine kernel-weighted magnitudes two edges after acceptance.
//          Optional macro SOBEL_DIR_SEL_EN adds a per-pixel dir_sel input
//          (0 = Gx mapping, 1 = Gy mapping); without it only Gx is produced.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int PIX_W  = c_PIX_W_DEF,
  parameter int DATA_W = c_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [PIX_W-1:0]  in_pixel,
`ifdef SOBEL_DIR_SEL_EN
  input  logic              dir_sel,
`endif
  output logic              out_valid,
  output logic              out_eof,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4,
  output logic [DATA_W-1:0] data5,
  output logic [DATA_W-1:0] data6,
  output logic [DATA_W-1:0] data7,
  output logic [DATA_W-1:0] data8,
  output logic [DATA_W-1:0] data9
);

  localparam int c_CW = $clog2(IMG_W);
  localparam int c_RW = $clog2(IMG_H);

  // Zero-extend a pixel and apply a weight of 1 or 2.
  function automatic logic [DATA_W-1:0] f_weight(input logic [PIX_W-1:0] p,
                                                 input int k);
    logic [DATA_W-1:0] ext;
    ext = DATA_W'(p);
    return (k == 2) ? (ext << 1) : ext;
  endfunction

  // Weight of tap i inside a group of three.
  function automatic int f_k(input int i);
    case (i)
      0:       return c_WK0;
      1:       return c_WK1;
      default: return c_WK2;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Raster position of the pixel presented this cycle
  // ---------------------------------------------------------------------------
  logic [c_CW-1:0] r_col, w_col, w_col_nxt;
  logic [c_RW-1:0] r_row, w_row, w_row_nxt;
  logic            w_col_last, w_row_last;
  logic            w_qual, w_eof;
  sobel_dir_t      w_dir;

`ifdef SOBEL_DIR_SEL_EN
  assign w_dir = sobel_dir_t'(dir_sel);
`else
  assign w_dir = DIR_GX;
`endif

  // Position of the incoming pixel (sof forces (0,0)) and the wrapped next count.
  always_comb begin
    w_col      = in_sof ? '0 : r_col;
    w_row      = in_sof ? '0 : r_row;
    w_col_last = (w_col == c_CW'(IMG_W - 1));
    w_row_last = (w_row == c_RW'(IMG_H - 1));
    w_col_nxt  = w_col_last ? '0 : w_col + 1'b1;
    w_row_nxt  = w_row;
    if (w_col_last) begin
      w_row_nxt = w_row_last ? '0 : w_row + 1'b1;
    end
    w_qual = (w_row >= c_RW'(2)) && (w_col >= c_CW'(2));
    w_eof  = w_row_last && w_col_last;
  end

  // Column/row counters advance only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb1 holds row r-1 and is accessed on acceptance; lb2 holds
  // row r-2 and is accessed one cycle later, fed by lb1's read data.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] w_lb1_q, w_lb2_q;
  logic             r_s1_acc, r_s1_qual, r_s1_eof;
  logic [PIX_W-1:0] r_s1_pix;
  logic [c_CW-1:0]  r_s1_col;
  sobel_dir_t       r_s1_dir;

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (c_CW)
  ) u_lb1 (
    .clk     (clk),
    .i_en    (in_valid),
    .i_addr  (w_col),
    .i_wdata (in_pixel),
    .o_rdata (w_lb1_q)
  );

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W),
    .AW    (c_CW)
  ) u_lb2 (
    .clk     (clk),
    .i_en    (r_s1_acc),
    .i_addr  (r_s1_col),
    .i_wdata (w_lb1_q),
    .o_rdata (w_lb2_q)
  );

  // Stage 1: capture the accepted pixel and its qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_acc  <= 1'b0;
      r_s1_pix  <= '0;
      r_s1_col  <= '0;
      r_s1_qual <= 1'b0;
      r_s1_eof  <= 1'b0;
      r_s1_dir  <= DIR_GX;
    end else begin
      r_s1_acc <= in_valid;
      if (in_valid) begin
        r_s1_pix  <= in_pixel;
        r_s1_col  <= w_col;
        r_s1_qual <= w_qual;
        r_s1_eof  <= w_eof;
        r_s1_dir  <= w_dir;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: newest window column {lb2 read, mid, bottom} becomes available.
  // ---------------------------------------------------------------------------
  logic             r_s2_acc, r_s2_qual, r_s2_eof;
  logic [PIX_W-1:0] r_s2_mid, r_s2_bot;
  sobel_dir_t       r_s2_dir;

  // Align the row r-1 and row r pixels with the row r-2 read from lb2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_acc  <= 1'b0;
      r_s2_mid  <= '0;
      r_s2_bot  <= '0;
      r_s2_qual <= 1'b0;
      r_s2_eof  <= 1'b0;
      r_s2_dir  <= DIR_GX;
    end else begin
      r_s2_acc <= r_s1_acc;
      if (r_s1_acc) begin
        r_s2_mid  <= w_lb1_q;
        r_s2_bot  <= r_s1_pix;
        r_s2_qual <= r_s1_qual;
        r_s2_eof  <= r_s1_eof;
        r_s2_dir  <= r_s1_dir;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window: columns 0 and 1 are registers, column 2 is the stage-2 column.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] r_win_c0 [3];
  logic [PIX_W-1:0] r_win_c1 [3];
  logic [PIX_W-1:0] w_win    [3][3];

  // Shift the older window columns left once per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_win_c0[i] <= '0;
        r_win_c1[i] <= '0;
      end
    end else if (r_s2_acc) begin
      for (int i = 0; i < 3; i++) begin
        r_win_c0[i] <= r_win_c1[i];
      end
      r_win_c1[0] <= w_lb2_q;
      r_win_c1[1] <= r_s2_mid;
      r_win_c1[2] <= r_s2_bot;
    end
  end

  // Assemble the full 3x3 window (row 0 = oldest line, column 2 = newest).
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_win[i][0] = r_win_c0[i];
      w_win[i][1] = r_win_c1[i];
    end
    w_win[0][2] = w_lb2_q;
    w_win[1][2] = r_s2_mid;
    w_win[2][2] = r_s2_bot;
  end

  // ---------------------------------------------------------------------------
  // Weighting and output register
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_d [9];
  logic [DATA_W-1:0] r_d [9];
  logic              w_emit;

  assign w_emit = r_s2_acc && r_s2_qual;

  // Map the window onto adder slots: slot 1 negative, slot 2 zero, slot 3 positive.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_d[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (r_s2_dir == DIR_GY) begin
        w_d[3*i]   = f_weight(w_win[0][i], f_k(i));
        w_d[3*i+2] = f_weight(w_win[2][i], f_k(i));
      end else begin
        w_d[3*i]   = f_weight(w_win[i][0], f_k(i));
        w_d[3*i+2] = f_weight(w_win[i][2], f_k(i));
      end
    end
  end

  // Register outputs; data holds its last value when no window is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      out_valid <= w_emit;
      out_eof   <= w_emit && r_s2_eof;
      if (w_emit) begin
        for (int i = 0; i < 9; i++) begin
          r_d[i] <= w_d[i];
        end
      end
    end
  end

  assign data1 = r_d[0];
  assign data2 = r_d[1];
  assign data3 = r_d[2];
  assign data4 = r_d[3];
  assign data5 = r_d[4];
  assign data6 = r_d[5];
  assign data7 = r_d[6];
  assign data8 = r_d[7];
  assign data9 = r_d[8];

endmodule

`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
// ============================================================================
// Module : tb_sobel_window_gen
// Brief  : Directed self-checking bench for sobel_window_gen on an 8x6 image.
//          With SOBEL_DIR_SEL_EN defined the Gy path is exercised as well.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sobel_window_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [PW-1:0] in_pixel;
`ifdef SOBEL_DIR_SEL_EN
  logic          dir_sel;
`endif
  logic          out_valid;
  logic          out_eof;
  logic [DW-1:0] data1, data2, data3, data4, data5, data6, data7, data8, data9;

  always #5 clk = ~clk;

  sobel_window_gen #(
    .IMG_W  (W),
    .IMG_H  (H),
    .PIX_W  (PW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
`ifdef SOBEL_DIR_SEL_EN
    .dir_sel   (dir_sel),
`endif
    .out_valid (out_valid),
    .out_eof   (out_eof),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .data4     (data4),
    .data5     (data5),
    .data6     (data6),
    .data7     (data7),
    .data8     (data8),
    .data9     (data9)
  );

  typedef struct packed {
    logic [9*DW-1:0] d;
    logic            eof;
    logic [31:0]     cyc;
  } win_t;

  win_t got[$];
  win_t exp_q[$];
  int   img [H][W];
  int   cyc = 0;
  int   acc22;
  int   checks = 0;
  int   failures = 0;

  localparam logic [9*DW-1:0] c_FLAT100 =
    {12'd100, 12'd0, 12'd100, 12'd200, 12'd0, 12'd200, 12'd100, 12'd0, 12'd100};
  localparam logic [9*DW-1:0] c_RAMP3 =
    {12'd20, 12'd0, 12'd40, 12'd40, 12'd0, 12'd80, 12'd20, 12'd0, 12'd40};
  localparam logic [9*DW-1:0] c_FLAT50 =
    {12'd50, 12'd0, 12'd50, 12'd100, 12'd0, 12'd100, 12'd50, 12'd0, 12'd50};

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every emitted window with the edge index it appeared on.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got.push_back(win_t'({data1, data2, data3, data4, data5, data6, data7,
                            data8, data9, out_eof, 32'(cyc)}));
    end
  end

  // Reference window for accepted pixel (r,c) from the stored image.
  function automatic logic [9*DW-1:0] f_exp(input int r, input int c, input bit gy);
    int d1, d3, d4, d6, d7, d9;
    if (!gy) begin
      d1 = img[r-2][c-2];   d3 = img[r-2][c];
      d4 = 2*img[r-1][c-2]; d6 = 2*img[r-1][c];
      d7 = img[r][c-2];     d9 = img[r][c];
    end else begin
      d1 = img[r-2][c-2];   d3 = img[r][c-2];
      d4 = 2*img[r-2][c-1]; d6 = 2*img[r][c-1];
      d7 = img[r-2][c];     d9 = img[r][c];
    end
    return {12'(d1), 12'd0, 12'(d3), 12'(d4), 12'd0, 12'(d6), 12'(d7), 12'd0, 12'(d9)};
  endfunction

  // Drive the first n_pix pixels of a frame (mode 0 flat, 1 col*10, 2 row*10).
  task automatic drive_frame(input int mode, input int base, input bit gap,
                             input bit gy, input int n_pix);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        img[r][c] = (mode == 0) ? base : (mode == 1) ? c*10 : r*10;
      end
    end
    for (int i = 0; i < n_pix; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_pixel = PW'(img[r][c]);
`ifdef SOBEL_DIR_SEL_EN
      dir_sel  = gy;
`endif
      if (r == 2 && c == 2) acc22 = cyc + 1;
      if (r >= 2 && c >= 2) begin
        exp_q.push_back(win_t'({f_exp(r, c, gy), (r == H-1 && c == W-1), 32'(cyc + 3)}));
      end
      @(posedge clk); #1;
      if (gap) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic flush();
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_pixel = '0;
`ifdef SOBEL_DIR_SEL_EN
    dir_sel = 1'b0;
`endif
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_eof !== 1'b0) begin
      failures++; $display("FAIL reset_eof got=%b exp=0", out_eof);
    end
    checks++;
    if ({data1, data2, data3, data4, data5, data6, data7, data8, data9} !== '0) begin
      failures++; $display("FAIL reset_data got=%h exp=0",
        {data1, data2, data3, data4, data5, data6, data7, data8, data9});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_flat();
    int n_eof;
    got.delete(); exp_q.delete();
    drive_frame(0, 100, 1'b0, 1'b0, W*H);
    flush();
    checks++;
    if (got.size() != 24) begin
      failures++; $display("FAIL flat_count got=%0d exp=24", got.size());
    end
    checks++;
    if (got.size() == 0 || got[0].d !== c_FLAT100) begin
      failures++; $display("FAIL flat_first_data got=%h exp=%h",
        (got.size() > 0) ? got[0].d : '0, c_FLAT100);
    end
    checks++;
    if (got.size() == 0 || got[0].cyc != 32'(acc22 + 2)) begin
      failures++; $display("FAIL flat_latency got_edge=%0d exp_edge=%0d",
        (got.size() > 0) ? got[0].cyc : 0, acc22 + 2);
    end
    n_eof = 0;
    foreach (got[i]) if (got[i].eof) n_eof++;
    checks++;
    if (n_eof != 1 || got.size() < 24 || got[23].eof !== 1'b1) begin
      failures++; $display("FAIL flat_eof got_count=%0d exp_count=1 on window 24", n_eof);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++; $display("FAIL flat_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i,
          got[i].d, got[i].eof, got[i].cyc, exp_q[i].d, exp_q[i].eof, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_ramp_gx();
    got.delete(); exp_q.delete();
    drive_frame(1, 0, 1'b0, 1'b0, W*H);
    flush();
    checks++;
    if (got.size() < 3 || got[2].d !== c_RAMP3) begin
      failures++; $display("FAIL ramp_col3 got=%h exp=%h",
        (got.size() > 2) ? got[2].d : '0, c_RAMP3);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++; $display("FAIL ramp_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++; $display("FAIL ramp_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i,
          got[i].d, got[i].eof, got[i].cyc, exp_q[i].d, exp_q[i].eof, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_gap();
    got.delete(); exp_q.delete();
    drive_frame(1, 0, 1'b1, 1'b0, W*H);
    flush();
    checks++;
    if (got.size() != 24) begin
      failures++; $display("FAIL gap_count got=%0d exp=24", got.size());
    end
    checks++;
    if (got.size() < 3 || got[2].d !== c_RAMP3) begin
      failures++; $display("FAIL gap_col3 got=%h exp=%h",
        (got.size() > 2) ? got[2].d : '0, c_RAMP3);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++; $display("FAIL gap_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i,
          got[i].d, got[i].eof, got[i].cyc, exp_q[i].d, exp_q[i].eof, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_sof_restart();
    got.delete(); exp_q.delete();
    drive_frame(0, 77, 1'b0, 1'b0, 3*W + 4);
    drive_frame(0, 50, 1'b0, 1'b0, W*H);
    flush();
    checks++;
    if (got.size() != 32) begin
      failures++; $display("FAIL sof_count got=%0d exp=32", got.size());
    end
    checks++;
    if (got.size() < 9 || got[8].d !== c_FLAT50 || got[8].cyc != 32'(acc22 + 2)) begin
      failures++; $display("FAIL sof_first_new got=%h@%0d exp=%h@%0d",
        (got.size() > 8) ? got[8].d : '0, (got.size() > 8) ? got[8].cyc : 0,
        c_FLAT50, acc22 + 2);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++; $display("FAIL sof_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i,
          got[i].d, got[i].eof, got[i].cyc, exp_q[i].d, exp_q[i].eof, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    got.delete(); exp_q.delete();
    drive_frame(0, 77, 1'b0, 1'b0, 3*W + 6);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_eof !== 1'b0) begin
      failures++; $display("FAIL rstmid_flags got=%b%b exp=00", out_valid, out_eof);
    end
    checks++;
    if ({data1, data2, data3, data4, data5, data6, data7, data8, data9} !== '0) begin
      failures++; $display("FAIL rstmid_data got=%h exp=0",
        {data1, data2, data3, data4, data5, data6, data7, data8, data9});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete(); exp_q.delete();
    @(posedge clk); #1;
    drive_frame(1, 0, 1'b0, 1'b0, W*H);
    flush();
    checks++;
    if (got.size() != 24) begin
      failures++; $display("FAIL rstmid_count got=%0d exp=24", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++; $display("FAIL rstmid_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i,
          got[i].d, got[i].eof, got[i].cyc, exp_q[i].d, exp_q[i].eof, exp_q[i].cyc);
      end
    end
  endtask

`ifdef SOBEL_DIR_SEL_EN
  task automatic test_dir_gy();
    got.delete(); exp_q.delete();
    drive_frame(2, 0, 1'b0, 1'b1, W*H);
    flush();
    checks++;
    if (got.size() < 13 || got[12].d !== c_RAMP3) begin
      failures++; $display("FAIL gy_row3 got=%h exp=%h",
        (got.size() > 12) ? got[12].d : '0, c_RAMP3);
    end
    checks++;
    if (got.size() != 24) begin
      failures++; $display("FAIL gy_count got=%0d exp=24", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++; $display("FAIL gy_win%0d got=%h/%b@%0d exp=%h/%b@%0d", i,
          got[i].d, got[i].eof, got[i].cyc, exp_q[i].d, exp_q[i].eof, exp_q[i].cyc);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_flat();
    test_ramp_gx();
    test_gap();
    test_sof_restart();
    test_reset_mid();
`ifdef SOBEL_DIR_SEL_EN
    test_dir_gy();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
